sample_feeder: RTL and testbench
================================

SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning sample memory entries.
REQ-002 SHALL have parameter AW, default 9, meaning address width, with DEPTH = 2**AW.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 clear  in  1  empties memory bookkeeping: count, index and epoch.
REQ-006 wrEn  in  1  load strobe, one sample per cycle.
REQ-007 wrX1, wrX2  in  7 signed each  sample features to load.
REQ-008 wrT  in  2 signed  sample target (+1/-1) to load.
REQ-009 requestFlag  in  1  neuron asks for next sample; held high until served.
REQ-010 done  in  1  neuron training finished.
REQ-011 dataReady  out  1  x1Input/x2Input/tInput valid.
REQ-012 x1Input, x2Input  out  7 signed each  served features.
REQ-013 tInput  out  2 signed  served target.
REQ-014 nInput  out  32  number of stored samples, zero-extended.
REQ-015 epoch  out  16  completed passes over the sample set.
REQ-016 wrErr  out  1  one-cycle pulse on a dropped write.

Function
REQ-017 States SHALL be IDLE, FETCH, PRESENT and HALT.
REQ-018 IDLE -> FETCH SHALL occur when requestFlag=1, done=0 and count>0 are all sampled.
REQ-019 FETCH SHALL perform a synchronous memory read at index and always proceed to PRESENT.
REQ-020 In PRESENT, dataReady=1 and the three data outputs SHALL be driven from registers and held stable.
REQ-021 Latency: dataReady SHALL rise exactly 2 cycles after the edge at which requestFlag is first sampled high in IDLE.
REQ-022 PRESENT -> IDLE SHALL occur on the edge at which requestFlag is sampled low; dataReady=0 from that edge.
REQ-023 On PRESENT -> IDLE, index SHALL advance by 1.
REQ-024 When index = count-1, index SHALL instead wrap to 0 and epoch SHALL increment, saturating at 16'hFFFF.
REQ-025 requestFlag=1 with count=0 SHALL keep the block in IDLE with dataReady=0, with no error.
REQ-026 done=1 sampled in any state SHALL go to HALT with dataReady=0; data outputs hold their last values.
REQ-027 HALT SHALL be left only by rst or clear, both of which go to IDLE.
REQ-028 A write SHALL be accepted only in IDLE with count<DEPTH and clear=0.
REQ-029 An accepted write SHALL store {wrX1,wrX2,wrT} at address count; count increments.
REQ-030 Any other wrEn=1 SHALL be dropped, and wrErr SHALL pulse on the next cycle.
REQ-031 If wrEn and the IDLE->FETCH condition coincide, the write SHALL be accepted and the FETCH SHALL proceed; the new sample joins the set at its index.
REQ-032 clear SHALL take priority over all but rst: count=0, index=0, epoch=0, dataReady=0, state IDLE; memory contents are don't-care.
REQ-033 nInput SHALL always equal count.

Reset
REQ-034 rst SHALL set state=IDLE, dataReady=0, x1Input=0, x2Input=0, tInput=0, count=0, index=0, epoch=0 and wrErr=0.
REQ-035 rst mid-PRESENT SHALL drop dataReady on the same edge.
REQ-036 Memory array SHALL NOT be reset.

Structure
REQ-037 A shared package SHALL hold the state enum, sample widths (X_W=7, T_W=2) and the sample record type {x1,x2,t}.
REQ-038 One sub-module SHALL exist: sample_ram, a single-port synchronous-read RAM, 16 bits wide and DEPTH deep, writing in IDLE and reading in FETCH.
REQ-039 The RTL SHALL fit in 120-400 lines including sample_ram.

Verification
REQ-040 Load (3,-2,+1),(-5,4,-1),(0,7,+1); pulse requestFlag -> dataReady 2 cycles later with x1=3, x2=-2, t=+1; nInput=3.
REQ-041 Four request/release cycles on 3 samples -> serves samples 0,1,2,0; epoch=1 after the third release.
REQ-042 requestFlag=1 with empty memory for 10 cycles -> dataReady stays 0, state IDLE.
REQ-043 Write DEPTH+1 samples -> last write dropped, wrErr pulses once, nInput=512.
REQ-044 Assert done during PRESENT -> dataReady=0 next edge, HALT; further requests ignored; clear -> IDLE, nInput=0.
REQ-045 rst asserted while dataReady=1 -> all outputs zero next cycle; a later request with no reload is not served.

Source files
------------

// File: rtl/sample_feeder_pkg.sv
// Purpose: shared sample widths, state encoding and sample record for the feeder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sample_feeder_pkg;

  localparam int X_W      = 7;
  localparam int T_W      = 2;
  localparam int SAMPLE_W = 2*X_W + T_W;

  // Legacy-compatible state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_FETCH   = 2'd1;
  localparam state_t ST_PRESENT = 2'd2;
  localparam state_t ST_HALT    = 2'd3;

  typedef struct packed {
    logic signed [X_W-1:0] x1;
    logic signed [X_W-1:0] x2;
    logic signed [T_W-1:0] t;
  } sample_t;

endpackage

// File: rtl/sample_feeder_if.sv
// Purpose: load/request/serve bundle between the neuron side and the sample feeder.
// Latency: n/a (wires only).
// Backpressure: requestFlag is held by the neuron until dataReady; writes never stall, they drop with wrErr.
// Ports: master drives clear/wrEn/wrX1/wrX2/wrT/requestFlag/done; slave drives dataReady,
//        x1Input/x2Input/tInput, nInput, epoch and wrErr.
interface sample_feeder_if;

  logic                                        clear;
  logic                                        wrEn;
  logic signed [sample_feeder_pkg::X_W-1:0]    wrX1;
  logic signed [sample_feeder_pkg::X_W-1:0]    wrX2;
  logic signed [sample_feeder_pkg::T_W-1:0]    wrT;
  logic                                        requestFlag;
  logic                                        done;

  logic                                        dataReady;
  logic signed [sample_feeder_pkg::X_W-1:0]    x1Input;
  logic signed [sample_feeder_pkg::X_W-1:0]    x2Input;
  logic signed [sample_feeder_pkg::T_W-1:0]    tInput;
  logic [31:0]                                 nInput;
  logic [15:0]                                 epoch;
  logic                                        wrErr;

  modport master (
    output clear, wrEn, wrX1, wrX2, wrT, requestFlag, done,
    input  dataReady, x1Input, x2Input, tInput, nInput, epoch, wrErr
  );

  modport slave (
    input  clear, wrEn, wrX1, wrX2, wrT, requestFlag, done,
    output dataReady, x1Input, x2Input, tInput, nInput, epoch, wrErr
  );

endinterface

// File: rtl/sample_ram.sv
// Purpose: single-port sample store, synchronous write and registered read.
// Latency: read data valid the cycle after re_i.
// Backpressure: none; caller guarantees write and read never share a cycle.
// Ports: clk_i; we_i/wdata_i write at addr_i; re_i loads rdata_o from addr_i. Not reset.
module sample_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int W     = 16
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sample_feeder.sv
// Purpose: stores training samples and serves them round-robin to a neuron on request.
// Latency: dataReady rises 2 cycles after requestFlag is first sampled in IDLE.
// Backpressure: sample held until requestFlag drops; writes outside IDLE or when full are dropped with wrErr.
// Ports: clk_i, rst_i (sync, active-high); bus = sample_feeder_if.slave.
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sample_feeder_if.slave  bus
);

  state_t          state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   index_q, index_d;
  logic [15:0]     epoch_q, epoch_d;
  logic            rdy_q, rdy_d;
  sample_t         out_q, out_d;
  logic            wr_err_q, wr_err_d;

  logic            wr_acc;
  logic            ram_re;
  logic [AW-1:0]   ram_addr;
  sample_t         wr_sample;
  logic [SAMPLE_W-1:0] ram_rdata;
  sample_t         rd_sample;
  logic            last_idx;

  assign wr_acc    = bus.wrEn && (state_q == ST_IDLE) && (count_q < (AW+1)'(DEPTH)) && !bus.clear;
  assign ram_re    = (state_q == ST_FETCH);
  // Reads happen only in FETCH and writes only in IDLE, so one address port suffices.
  assign ram_addr  = ram_re ? index_q : count_q[AW-1:0];
  assign wr_sample = '{x1: bus.wrX1, x2: bus.wrX2, t: bus.wrT};
  assign rd_sample = sample_t'(ram_rdata);
  assign last_idx  = ({1'b0, index_q} == (count_q - 1'b1));

  sample_ram #(.DEPTH(DEPTH), .AW(AW), .W(SAMPLE_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_acc),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (wr_sample),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    index_d  = index_q;
    epoch_d  = epoch_q;
    rdy_d    = rdy_q;
    out_d    = out_q;
    wr_err_d = bus.wrEn && !wr_acc;

    if (wr_acc) count_d = count_q + 1'b1;

    if (bus.clear) begin
      state_d = ST_IDLE;
      count_d = '0;
      index_d = '0;
      epoch_d = '0;
      rdy_d   = 1'b0;
    end else if (bus.done) begin
      state_d = ST_HALT;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.requestFlag && (count_q != '0)) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          state_d = ST_PRESENT;
        end
        ST_PRESENT: begin
          // First PRESENT cycle captures the RAM word; the release is only
          // honoured once the sample has actually been shown.
          if (!rdy_q) begin
            rdy_d = 1'b1;
            out_d = rd_sample;
          end else if (!bus.requestFlag) begin
            state_d = ST_IDLE;
            rdy_d   = 1'b0;
            if (last_idx) begin
              index_d = '0;
              if (epoch_q != 16'hFFFF) epoch_d = epoch_q + 1'b1;
            end else begin
              index_d = index_q + 1'b1;
            end
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      index_q  <= '0;
      epoch_q  <= '0;
      rdy_q    <= 1'b0;
      out_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      index_q  <= index_d;
      epoch_q  <= epoch_d;
      rdy_q    <= rdy_d;
      out_q    <= out_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.dataReady = rdy_q;
  assign bus.x1Input   = out_q.x1;
  assign bus.x2Input   = out_q.x2;
  assign bus.tInput    = out_q.t;
  assign bus.nInput    = {{(31-AW){1'b0}}, count_q};
  assign bus.epoch     = epoch_q;
  assign bus.wrErr     = wr_err_q;

endmodule

// File: tb/tb_sample_feeder.sv
// Purpose: directed bench for sample_feeder: load, serve, wrap, overflow, halt, clear, reset.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: requestFlag held until dataReady, as a real neuron would.
module tb_sample_feeder;
  import sample_feeder_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sample_feeder_if bus ();

  sample_feeder #(.DEPTH(512), .AW(9)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input logic signed [6:0] ex1,
                            input logic signed [6:0] ex2, input logic signed [1:0] et);
    chk({tag, ".rdy"}, {31'b0, bus.dataReady}, 32'd1);
    chk({tag, ".x1"},  {25'b0, bus.x1Input},   {25'b0, ex1});
    chk({tag, ".x2"},  {25'b0, bus.x2Input},   {25'b0, ex2});
    chk({tag, ".t"},   {30'b0, bus.tInput},    {30'b0, et});
  endtask

  // Request, wait the fixed 2-cycle latency, check the sample, release, check epoch.
  task automatic serve(input string tag, input logic signed [6:0] ex1,
                       input logic signed [6:0] ex2, input logic signed [1:0] et,
                       input logic [15:0] exp_epoch);
    bus.requestFlag = 1'b1;
    step();
    step();
    step();
    chk_sample(tag, ex1, ex2, et);
    bus.requestFlag = 1'b0;
    step();
    chk({tag, ".rel_rdy"}, {31'b0, bus.dataReady}, 32'd0);
    chk({tag, ".epoch"},   {16'b0, bus.epoch},     {16'b0, exp_epoch});
  endtask

  task automatic write(input logic signed [6:0] x1, input logic signed [6:0] x2,
                       input logic signed [1:0] t);
    bus.wrEn = 1'b1;
    bus.wrX1 = x1;
    bus.wrX2 = x2;
    bus.wrT  = t;
    step();
    bus.wrEn = 1'b0;
  endtask

  initial begin
    logic fill_err;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.wrEn = 1'b0;
    bus.wrX1 = '0;
    bus.wrX2 = '0;
    bus.wrT = '0;
    bus.requestFlag = 1'b0;
    bus.done = 1'b0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst.rdy",   {31'b0, bus.dataReady}, 32'd0);
    chk("rst.x1",    {25'b0, bus.x1Input},   32'd0);
    chk("rst.x2",    {25'b0, bus.x2Input},   32'd0);
    chk("rst.t",     {30'b0, bus.tInput},    32'd0);
    chk("rst.n",     bus.nInput,             32'd0);
    chk("rst.epoch", {16'b0, bus.epoch},     32'd0);
    chk("rst.wrerr", {31'b0, bus.wrErr},     32'd0);

    // Load three samples
    write(7'sd3, -7'sd2, 2'sd1);
    write(-7'sd5, 7'sd4, -2'sd1);
    write(7'sd0, 7'sd7, 2'sd1);
    chk("load.n",     bus.nInput,         32'd3);
    chk("load.wrerr", {31'b0, bus.wrErr}, 32'd0);

    // First request: exact 2-cycle latency, stable while held
    bus.requestFlag = 1'b1;
    step();
    chk("lat.e0", {31'b0, bus.dataReady}, 32'd0);
    step();
    chk("lat.e1", {31'b0, bus.dataReady}, 32'd0);
    step();
    chk_sample("lat.e2", 7'sd3, -7'sd2, 2'sd1);
    step();
    chk_sample("hold", 7'sd3, -7'sd2, 2'sd1);
    bus.requestFlag = 1'b0;
    step();
    chk("rel0.rdy",   {31'b0, bus.dataReady}, 32'd0);
    chk("rel0.epoch", {16'b0, bus.epoch},     32'd0);

    // Round robin with wrap
    serve("s1", -7'sd5, 7'sd4, -2'sd1, 16'd0);
    serve("s2", 7'sd0, 7'sd7, 2'sd1, 16'd1);
    serve("s0b", 7'sd3, -7'sd2, 2'sd1, 16'd1);

    // done during PRESENT -> HALT, outputs held
    bus.requestFlag = 1'b1;
    step();
    step();
    step();
    chk_sample("pre_done", -7'sd5, 7'sd4, -2'sd1);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    chk("halt.rdy", {31'b0, bus.dataReady}, 32'd0);
    chk("halt.x1",  {25'b0, bus.x1Input},   {25'b0, -7'sd5});
    chk("halt.st",  {30'b0, dut.state_q},   {30'b0, ST_HALT});
    step();
    step();
    step();
    step();
    chk("halt.ignore", {31'b0, bus.dataReady}, 32'd0);
    write(7'sd1, 7'sd1, 2'sd1);
    chk("halt.wrerr",  {31'b0, bus.wrErr}, 32'd1);
    chk("halt.n",      bus.nInput,         32'd3);
    step();
    chk("halt.wrerr1", {31'b0, bus.wrErr}, 32'd0);
    bus.requestFlag = 1'b0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clr.n",     bus.nInput,           32'd0);
    chk("clr.epoch", {16'b0, bus.epoch},   32'd0);
    chk("clr.st",    {30'b0, dut.state_q}, {30'b0, ST_IDLE});

    // Request with empty memory
    bus.requestFlag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("empty.rdy", {31'b0, bus.dataReady}, 32'd0);
    end
    chk("empty.st",    {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    chk("empty.wrerr", {31'b0, bus.wrErr},   32'd0);
    bus.requestFlag = 1'b0;

    // Fill to DEPTH, then one overflow write
    fill_err = 1'b0;
    bus.wrEn = 1'b1;
    for (int i = 0; i < 512; i++) begin
      bus.wrX1 = 7'(i);
      bus.wrX2 = ~7'(i);
      bus.wrT  = i[0] ? 2'sd1 : -2'sd1;
      step();
      if (bus.wrErr !== 1'b0) fill_err = 1'b1;
    end
    chk("fill.noerr", {31'b0, fill_err}, 32'd0);
    chk("fill.n",     bus.nInput,        32'd512);
    step();
    bus.wrEn = 1'b0;
    chk("ovf.wrerr",  {31'b0, bus.wrErr}, 32'd1);
    chk("ovf.n",      bus.nInput,         32'd512);
    step();
    chk("ovf.wrerr1", {31'b0, bus.wrErr}, 32'd0);

    // Serve first of the full set and stay in PRESENT
    bus.requestFlag = 1'b1;
    step();
    step();
    step();
    chk_sample("full.s0", 7'sd0, -7'sd1, -2'sd1);

    // rst while dataReady=1
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2.rdy",   {31'b0, bus.dataReady}, 32'd0);
    chk("rst2.x1",    {25'b0, bus.x1Input},   32'd0);
    chk("rst2.x2",    {25'b0, bus.x2Input},   32'd0);
    chk("rst2.t",     {30'b0, bus.tInput},    32'd0);
    chk("rst2.n",     bus.nInput,             32'd0);
    chk("rst2.epoch", {16'b0, bus.epoch},     32'd0);
    step();
    step();
    step();
    chk("rst2.noserve", {31'b0, bus.dataReady}, 32'd0);
    bus.requestFlag = 1'b0;
    step();

    // Write coinciding with the IDLE->FETCH decision
    write(7'sd5, -7'sd3, 2'sd1);
    bus.wrEn = 1'b1;
    bus.wrX1 = -7'sd6;
    bus.wrX2 = 7'sd2;
    bus.wrT  = -2'sd1;
    bus.requestFlag = 1'b1;
    step();
    bus.wrEn = 1'b0;
    chk("coin.wrerr", {31'b0, bus.wrErr}, 32'd0);
    step();
    step();
    chk_sample("coin", 7'sd5, -7'sd3, 2'sd1);
    chk("coin.n", bus.nInput, 32'd2);
    bus.requestFlag = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
